// File: rtl/tft_draw_ctrl.sv
// tft_draw_ctrl: arbitrates the TFT byte port between the init sequencer and
// the rectangle draw path. Draw commands emit CASET/PASET/RAMWR followed by
// RGB666 pixels sent as three left-justified bytes.
module tft_draw_ctrl #(
  parameter int COORD_W = 9,
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_dc,
  input  logic [7:0]         init_data,
  input  logic               init_transmit,
  input  logic               init_finished,
  input  logic               tft_busy,
  output logic               tft_dc,
  output logic [7:0]         tft_data,
  output logic               tft_transmit,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_y1,
  output logic               cmd_err,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [17:0]        pix_data,
  output logic               frame_done,
  output logic               drawing
);

  localparam int NPIX_W = 2*COORD_W+1;
  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(WIDTH);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(HEIGHT);

  typedef enum logic [3:0] {
    S_WAITINIT, S_IDLE, S_CASET, S_CASET_ARG, S_PASET, S_PASET_ARG,
    S_RAMWR, S_PIX_FETCH, S_PIX_G, S_PIX_B
  } state_t;

  state_t              state;
  logic                guard;
  logic [1:0]          arg_cnt;
  logic [COORD_W-1:0]  x0_q, x1_q, y0_q, y1_q;
  logic [NPIX_W-1:0]   npix;
  logic [5:0]          pix_g, pix_b;

  logic                can_issue, cmd_bad;
  logic [COORD_W:0]    dx, dy;
  logic [NPIX_W-1:0]   npix_new;
  logic [15:0]         arg_a, arg_b;
  logic [7:0]          arg_byte;

  // Issue qualification, command validation, pixel count and argument byte mux
  always_comb begin
    can_issue = ~tft_busy & ~guard;
    cmd_bad   = (cmd_x0 > cmd_x1) | (cmd_y0 > cmd_y1) |
                ({1'b0, cmd_x1} >= W_LIM) | ({1'b0, cmd_y1} >= H_LIM);
    dx        = {1'b0, cmd_x1} - {1'b0, cmd_x0} + (COORD_W+1)'(1);
    dy        = {1'b0, cmd_y1} - {1'b0, cmd_y0} + (COORD_W+1)'(1);
    npix_new  = NPIX_W'(dx) * NPIX_W'(dy);
    arg_a     = (state == S_PASET_ARG) ? 16'(y0_q) : 16'(x0_q);
    arg_b     = (state == S_PASET_ARG) ? 16'(y1_q) : 16'(x1_q);
    case (arg_cnt)
      2'd0:    arg_byte = arg_a[15:8];
      2'd1:    arg_byte = arg_a[7:0];
      2'd2:    arg_byte = arg_b[15:8];
      default: arg_byte = arg_b[7:0];
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign pix_ready = (state == S_PIX_FETCH) & can_issue;

  // Main sequencer; leaving S_WAITINIT is the sticky record that init finished
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_WAITINIT;
      guard        <= 1'b0;
      arg_cnt      <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      npix         <= '0;
      pix_g        <= '0;
      pix_b        <= '0;
      tft_dc       <= 1'b0;
      tft_data     <= '0;
      tft_transmit <= 1'b0;
      cmd_err      <= 1'b0;
      frame_done   <= 1'b0;
      drawing      <= 1'b0;
    end else begin
      tft_transmit <= 1'b0;
      cmd_err      <= 1'b0;
      frame_done   <= 1'b0;
      guard        <= 1'b0;
      case (state)
        S_WAITINIT: begin
          tft_dc       <= init_dc;
          tft_data     <= init_data;
          tft_transmit <= init_transmit;
          if (init_finished) state <= S_IDLE;
        end
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              cmd_err <= 1'b1;
            end else begin
              x0_q    <= cmd_x0;
              x1_q    <= cmd_x1;
              y0_q    <= cmd_y0;
              y1_q    <= cmd_y1;
              npix    <= npix_new;
              arg_cnt <= '0;
              drawing <= 1'b1;
              state   <= S_CASET;
            end
          end
        end
        S_CASET, S_PASET, S_RAMWR: begin
          if (can_issue) begin
            tft_transmit <= 1'b1;
            guard        <= 1'b1;
            tft_dc       <= 1'b0;
            if (state == S_CASET) begin
              tft_data <= 8'h2a;
              state    <= S_CASET_ARG;
            end else if (state == S_PASET) begin
              tft_data <= 8'h2b;
              state    <= S_PASET_ARG;
            end else begin
              tft_data <= 8'h2c;
              state    <= S_PIX_FETCH;
            end
          end
        end
        S_CASET_ARG, S_PASET_ARG: begin
          if (can_issue) begin
            tft_transmit <= 1'b1;
            guard        <= 1'b1;
            tft_dc       <= 1'b1;
            tft_data     <= arg_byte;
            arg_cnt      <= arg_cnt + 2'd1;
            if (arg_cnt == 2'd3)
              state <= (state == S_CASET_ARG) ? S_PASET : S_RAMWR;
          end
        end
        S_PIX_FETCH: begin
          if (pix_valid && can_issue) begin
            pix_g        <= pix_data[11:6];
            pix_b        <= pix_data[5:0];
            tft_transmit <= 1'b1;
            guard        <= 1'b1;
            tft_dc       <= 1'b1;
            tft_data     <= {pix_data[17:12], 2'b00};
            state        <= S_PIX_G;
          end
        end
        S_PIX_G: begin
          if (can_issue) begin
            tft_transmit <= 1'b1;
            guard        <= 1'b1;
            tft_dc       <= 1'b1;
            tft_data     <= {pix_g, 2'b00};
            state        <= S_PIX_B;
          end
        end
        S_PIX_B: begin
          if (can_issue) begin
            tft_transmit <= 1'b1;
            guard        <= 1'b1;
            tft_dc       <= 1'b1;
            tft_data     <= {pix_b, 2'b00};
            npix         <= npix - NPIX_W'(1);
            if (npix == NPIX_W'(1)) begin
              frame_done <= 1'b1;
              drawing    <= 1'b0;
              state      <= S_IDLE;
            end else begin
              state <= S_PIX_FETCH;
            end
          end
        end
        default: state <= S_WAITINIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_draw_ctrl.sv
// tb_tft_draw_ctrl: randomized draw commands checked against a byte-stream
// model built from the rectangle and pixel list, with a busy-holding
// transmitter model.
module tb_tft_draw_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init_dc = 1'b0, init_transmit = 1'b0, init_finished = 1'b0;
  logic [7:0] init_data = '0;
  logic       tft_busy;
  logic       tft_dc, tft_transmit;
  logic [7:0] tft_data;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_err;
  logic [8:0] cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
  logic       pix_valid = 1'b0, pix_ready;
  logic [17:0] pix_data = '0;
  logic       frame_done, drawing;

  int vectors = 0, miscompares = 0;

  tft_draw_ctrl dut (
    .clk(clk), .rst(rst),
    .init_dc(init_dc), .init_data(init_data), .init_transmit(init_transmit),
    .init_finished(init_finished), .tft_busy(tft_busy),
    .tft_dc(tft_dc), .tft_data(tft_data), .tft_transmit(tft_transmit),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_err(cmd_err), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .frame_done(frame_done), .drawing(drawing)
  );

  always #5 clk = ~clk;

  // Transmitter model: after each pulse stays busy for a random number of cycles
  int busy_cnt, busy_lo = 0, busy_hi = 0;
  always @(posedge clk or negedge rst)
    if (!rst) busy_cnt <= 0;
    else if (tft_transmit) busy_cnt <= int'($urandom_range(busy_hi, busy_lo));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  assign tft_busy = (busy_cnt != 0);

  // Observed byte stream and event counters
  logic [8:0] cap[$];
  int fd_cnt = 0, err_cnt = 0, hs_cnt = 0, viol = 0;
  always @(negedge clk) begin
    if (tft_transmit) begin
      cap.push_back({tft_dc, tft_data});
      if (tft_busy) viol++;
    end
    if (frame_done) fd_cnt++;
    if (cmd_err) err_cnt++;
    if (pix_valid && pix_ready) hs_cnt++;
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tft_dc, tft_data, tft_transmit, cmd_ready, cmd_err, pix_ready, frame_done, drawing} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got dc=%b data=%h tx=%b rdy=%b err=%b prdy=%b fd=%b drw=%b want all 0",
               tft_dc, tft_data, tft_transmit, cmd_ready, cmd_err, pix_ready, frame_done, drawing);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_init_passthrough;
    logic       dcv;
    logic [7:0] dv;
    for (int i = 0; i < 4; i++) begin
      dcv = (i == 0) ? 1'b0 : 1'($urandom);
      dv  = (i == 0) ? 8'hc0 : 8'($urandom);
      @(posedge clk); #1;
      init_dc = dcv; init_data = dv; init_transmit = 1'b1;
      @(negedge clk);
      vectors++;
      if (tft_transmit !== 1'b0) begin
        miscompares++; $display("FAIL init_latency: got tx=%b want 0", tft_transmit);
      end
      @(posedge clk); #1 init_transmit = 1'b0; init_data = 8'($urandom);
      @(negedge clk);
      vectors++;
      if ({tft_transmit, tft_dc, tft_data} !== {1'b1, dcv, dv}) begin
        miscompares++;
        $display("FAIL init_pass: got tx=%b dc=%b data=%h want tx=1 dc=%b data=%h", tft_transmit, tft_dc, tft_data, dcv, dv);
      end
      @(negedge clk);
      vectors++;
      if (tft_transmit !== 1'b0 || cmd_ready !== 1'b0) begin
        miscompares++; $display("FAIL init_pulse_end: got tx=%b rdy=%b want 0 0", tft_transmit, cmd_ready);
      end
      repeat (4) @(negedge clk);
    end
    @(posedge clk); #1 init_finished = 1'b1;
    @(posedge clk); #1 init_finished = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL init_done_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic run_draw(input int x0, input int x1, input int y0, input int y1,
                          input bit ones, input int starve_k, input string name);
    logic [17:0] pixq[$];
    logic [8:0]  expq[$];
    int n, k, cyc, fd0, hs0, v0, wp;
    bit starved;
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int i = 0; i < n; i++) pixq.push_back(ones ? 18'h3ffff : 18'($urandom));
    expq.push_back({1'b0, 8'h2a});
    expq.push_back({1'b1, 8'(x0 / 256)}); expq.push_back({1'b1, 8'(x0 % 256)});
    expq.push_back({1'b1, 8'(x1 / 256)}); expq.push_back({1'b1, 8'(x1 % 256)});
    expq.push_back({1'b0, 8'h2b});
    expq.push_back({1'b1, 8'(y0 / 256)}); expq.push_back({1'b1, 8'(y0 % 256)});
    expq.push_back({1'b1, 8'(y1 / 256)}); expq.push_back({1'b1, 8'(y1 % 256)});
    expq.push_back({1'b0, 8'h2c});
    foreach (pixq[i]) begin
      expq.push_back({1'b1, 8'((pixq[i] / 4096) * 4)});
      expq.push_back({1'b1, 8'(((pixq[i] / 64) % 64) * 4)});
      expq.push_back({1'b1, 8'((pixq[i] % 64) * 4)});
    end
    cap.delete(); fd0 = fd_cnt; hs0 = hs_cnt; v0 = viol;
    @(posedge clk); #1;
    cmd_x0 = 9'(x0); cmd_x1 = 9'(x1); cmd_y0 = 9'(y0); cmd_y1 = 9'(y1); cmd_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (drawing !== 1'b1) begin
      miscompares++; $display("FAIL %s drawing_set: got %b want 1", name, drawing);
    end
    @(posedge clk); #1;
    k = 0; cyc = 0; starved = 0;
    while (fd_cnt == fd0 && cyc < 5000) begin
      if (k < n && !(k == starve_k && !starved)) pix_valid = ($urandom_range(3, 0) != 0);
      else pix_valid = 1'b0;
      pix_data = (k < n) ? pixq[k] : 18'($urandom);
      @(negedge clk);
      if (pix_valid && pix_ready) k++;
      else if (k == starve_k && !starved && pix_ready) begin
        wp = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (tft_transmit) wp++;
        end
        starved = 1;
        vectors++;
        if (wp !== 0) begin
          miscompares++; $display("FAIL %s starve_pulses: got %0d want 0", name, wp);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 1'b0;
    vectors++;
    if (fd_cnt == fd0) begin
      miscompares++; $display("FAIL %s timeout: got no frame_done after %0d cycles want frame_done", name, cyc);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (cap.size() != expq.size()) begin
      miscompares++; $display("FAIL %s byte_count: got %0d want %0d", name, cap.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      vectors++;
      if (cap[i] !== expq[i]) begin
        miscompares++; $display("FAIL %s byte[%0d]: got dc/data %h want %h", name, i, cap[i], expq[i]);
      end
    end
    vectors++;
    if (fd_cnt - fd0 != 1 || hs_cnt - hs0 != n || viol != v0) begin
      miscompares++;
      $display("FAIL %s events: got fd=%0d hs=%0d busy_viol=%0d want fd=1 hs=%0d busy_viol=0",
               name, fd_cnt - fd0, hs_cnt - hs0, viol - v0, n);
    end
    vectors++;
    if (drawing !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s end_state: got drawing=%b rdy=%b want 0 1", name, drawing, cmd_ready);
    end
  endtask

  task automatic test_single_pixel;
    busy_lo = 4; busy_hi = 4;
    run_draw(0, 0, 0, 0, 1'b1, -1, "single_pixel");
    vectors++;
    if (cap.size() != 14) begin
      miscompares++; $display("FAIL single_pulses: got %0d want 14", cap.size());
    end
  endtask

  task automatic test_rect;
    busy_lo = 0; busy_hi = 3;
    run_draw(10, 11, 300, 301, 1'b0, -1, "rect");
    run_draw(318, 319, 478, 479, 1'b0, -1, "max_corner");
  endtask

  task automatic test_invalid;
    int tx0[4] = '{5, 0, 0, 0};
    int tx1[4] = '{3, 320, 0, 0};
    int ty0[4] = '{0, 0, 0, 7};
    int ty1[4] = '{0, 0, 480, 6};
    int e0;
    for (int i = 0; i < 4; i++) begin
      e0 = err_cnt; cap.delete();
      @(posedge clk); #1;
      cmd_x0 = 9'(tx0[i]); cmd_x1 = 9'(tx1[i]); cmd_y0 = 9'(ty0[i]); cmd_y1 = 9'(ty1[i]); cmd_valid = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (6) @(negedge clk);
      vectors++;
      if (err_cnt - e0 != 1 || cap.size() != 0 || cmd_ready !== 1'b1 || drawing !== 1'b0) begin
        miscompares++;
        $display("FAIL invalid[%0d]: got err=%0d tx=%0d rdy=%b drw=%b want err=1 tx=0 rdy=1 drw=0",
                 i, err_cnt - e0, cap.size(), cmd_ready, drawing);
      end
    end
  endtask

  task automatic test_starvation;
    busy_lo = 0; busy_hi = 2;
    run_draw(3, 5, 20, 21, 1'b0, 2, "starve");
  endtask

  task automatic test_back_to_back;
    int x0, y0;
    for (int i = 0; i < 6; i++) begin
      busy_lo = 0; busy_hi = int'($urandom_range(3, 0));
      x0 = int'($urandom_range(319, 0));
      y0 = int'($urandom_range(479, 0));
      run_draw(x0, (x0 + int'($urandom_range(2, 0)) > 319) ? 319 : x0 + int'($urandom_range(2, 0)),
               y0, (y0 + int'($urandom_range(2, 0)) > 479) ? 479 : y0 + int'($urandom_range(2, 0)),
               1'b0, -1, "random");
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    busy_lo = 0; busy_hi = 0;
    @(posedge clk); #1;
    cmd_x0 = 9'd0; cmd_x1 = 9'd1; cmd_y0 = 9'd0; cmd_y1 = 9'd0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 18'($urandom);
    cyc = 0;
    @(negedge clk);
    while (!pix_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!pix_ready) begin
      miscompares++; $display("FAIL reset_mid_timeout: got no pix_ready want pix_ready");
    end
    @(posedge clk); #2;
    pix_valid = 1'b0;
    vectors++;
    if (tft_transmit !== 1'b1 || drawing !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_pre: got tx=%b drw=%b want 1 1", tft_transmit, drawing);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({tft_dc, tft_data, tft_transmit, cmd_ready, cmd_err, pix_ready, frame_done, drawing} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got dc=%b data=%h tx=%b rdy=%b prdy=%b drw=%b want all 0",
               tft_dc, tft_data, tft_transmit, cmd_ready, pix_ready, drawing);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0 || tft_transmit !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_rearm: got rdy=%b tx=%b want 0 0", cmd_ready, tft_transmit);
    end
    @(posedge clk); #1 init_finished = 1'b1;
    @(posedge clk); #1 init_finished = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_reinit: got rdy=%b want 1", cmd_ready);
    end
    run_draw(7, 7, 9, 10, 1'b0, -1, "after_reset");
  endtask

  initial begin
    test_reset;
    test_init_passthrough;
    test_single_pixel;
    test_rect;
    test_invalid;
    test_starvation;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tft_draw_ctrl.md
Name: tft_draw_ctrl

Overview:
- Owns the single TFT byte-transmit port and shares it between the power-up init sequencer and the drawing path.
- Passes init traffic straight through until init reports finished. After that, it accepts rectangle-draw commands.
- For each command it issues CASET (0x2a) and PASET (0x2b) with their arguments, then RAMWR (0x2c), then streams RGB666 pixels (3 bytes each) from a pixel source.
- Sits between tft_init / pixel generators and the TFT serial transmitter.

Parameters:
- COORD_W, 9, width of each x/y coordinate.
- WIDTH, 320, number of columns; x must be < WIDTH.
- HEIGHT, 480, number of rows; y must be < HEIGHT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- init_dc  in  1  init sequencer D/C
- init_data  in  8  init sequencer byte
- init_transmit  in  1  init sequencer transmit pulse
- init_finished  in  1  init sequence complete
- tft_busy  in  1  transmitter busy
- tft_dc  out  1  D/C to transmitter (0 = command, 1 = data)
- tft_data  out  8  byte to transmitter
- tft_transmit  out  1  one-cycle transmit pulse
- cmd_valid  in  1  rectangle command valid
- cmd_ready  out  1  ready for a command
- cmd_x0, cmd_x1, cmd_y0, cmd_y1  in  COORD_W each  inclusive rectangle bounds
- cmd_err  out  1  one-cycle pulse when a command is rejected
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted this cycle
- pix_data  in  18  {r[5:0], g[5:0], b[5:0]}
- frame_done  out  1  one-cycle pulse after the last pixel byte is issued
- drawing  out  1  high from command accept to frame_done

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; state S_WAITINIT; guard, counters and latches cleared.
- S_WAITINIT:
  - tft_dc, tft_data and tft_transmit are registered copies of the init_* inputs (one-cycle latency).
  - cmd_ready = 0.
  - On init_finished = 1, latch "init_seen" and go to S_IDLE. Later deassertion of init_finished is ignored until reset.
- Byte issue rule (all states except S_WAITINIT): a byte is issued only when tft_busy = 0 and guard = 0.
  - Issuing means: tft_transmit = 1 for exactly one cycle, with tft_dc and tft_data valid in the same cycle.
  - guard is set in the issue cycle and cleared the following cycle. This gives a minimum 2-cycle spacing, tolerating a transmitter that raises busy one cycle late.
- S_IDLE:
  - cmd_ready = 1. On cmd_valid & cmd_ready, capture x0, x1, y0, y1.
  - Reject if x0 > x1, y0 > y1, x1 >= WIDTH or y1 >= HEIGHT: pulse cmd_err next cycle and stay in S_IDLE.
  - Otherwise: drawing = 1, npix = (x1 - x0 + 1) * (y1 - y0 + 1), computed at 2*COORD_W+1 bits and registered. Go to S_CASET.
- S_CASET: issue cmd 0x2a (dc = 0) -> S_CASET_ARG.
- S_CASET_ARG: issue 4 data bytes (dc = 1): x0[15:8], x0[7:0], x1[15:8], x1[7:0]; coordinates are zero-extended to 16 bits. -> S_PASET.
- S_PASET / S_PASET_ARG: same as CASET using 0x2b and y0, y1. -> S_RAMWR.
- S_RAMWR: issue 0x2c (dc = 0) -> S_PIX_FETCH.
- S_PIX_FETCH:
  - pix_ready = 1 only while the byte issue rule holds.
  - On pix_valid & pix_ready, latch the pixel and issue byte {r, 2'b00} in the same cycle. -> S_PIX_G.
- S_PIX_G: issue {g, 2'b00} -> S_PIX_B.
- S_PIX_B:
  - Issue {b, 2'b00} and decrement npix.
  - If npix was 1: pulse frame_done next cycle, drawing = 0, go to S_IDLE.
  - Otherwise go to S_PIX_FETCH.
- Pixel starvation: if pix_valid stays low, the controller waits indefinitely in S_PIX_FETCH with no transmit pulses.
- cmd_valid outside S_IDLE: ignored (cmd_ready = 0); the requester holds it.
- Minimum rectangle (x0 = x1, y0 = y1): exactly 1 pixel, 3 data bytes.
- Reset mid-draw: the transfer is abandoned immediately. After release the block returns to S_WAITINIT and re-requires init_finished.
- Total bytes per command: 11 + 3*npix.

Test Plan:
- Init passthrough: pulse init_transmit with dc = 0, data = 0xc0 -> tft_transmit pulses one cycle later with data 0xc0, dc = 0; cmd_ready stays 0 before init_finished.
- Single pixel (0,0)-(0,0), pix_data = 18'h3ffff, transmitter holds busy 4 cycles after each pulse -> byte stream 2a, 00 00 00 00, 2b, 00 00 00 00, 2c, fc fc fc; 14 pulses; frame_done pulses once; no pulse while busy.
- Rectangle x 10..11, y 300..301 -> CASET args 00 0a 00 0b; PASET args 01 2c 01 2d; exactly 4 pix_ready handshakes; 12 data bytes after 0x2c.
- Invalid command x0 = 5, x1 = 3 -> cmd_err pulses once, no tft_transmit, cmd_ready remains 1.
- Pixel starvation: hold pix_valid = 0 for 50 cycles mid-frame -> no tft_transmit in that window; resuming completes the frame with the correct byte count.
- Async reset asserted mid-PIX_G -> outputs go to 0 immediately without a clock edge; after release, cmd_ready = 0 until init_finished is seen again.
